vx_mem_credit_buffer: RTL and testbench
=======================================

// Module: vx_mem_credit_buffer
// PURPOSE
//  Request/response buffering stage directly upstream of the Vortex-to-AXI adapter.
//  Queues core memory requests and issues them to the adapter.
//  Limits outstanding reads with a credit counter sized to the response FIFO, so the
//  adapter's rsp-ready (AXI rready) is held at 1 and AXI R never backpressures.
//  Decouples core response stalls from the AXI fabric.
// PARAMETERS
//  DATA_WIDTH    512                     line width, bits (= adapter VX_DATA_WIDTH)
//  ADDR_WIDTH    26                      line address width (32 - log2(DATA_WIDTH/8))
//  TAG_WIDTH     8                       request tag width, returned unchanged with the response
//  REQ_DEPTH     4                       request FIFO entries, power of 2, >=2
//  RSP_DEPTH     8                       response FIFO entries = read credits, power of 2, >=2
//  BYTEEN_WIDTH  DATA_WIDTH/8            derived, byte enables
// PORTS
//  clk             in   1             clock
//  reset           in   1             synchronous, active-high
//  core_req_valid  in   1             core request valid
//  core_req_rw     in   1             1 = write, 0 = read
//  core_req_byteen in   BYTEEN_WIDTH  write byte enables
//  core_req_addr   in   ADDR_WIDTH    line address
//  core_req_data   in   DATA_WIDTH    write data
//  core_req_tag    in   TAG_WIDTH     request tag
//  core_req_ready  out  1             request FIFO not full
//  core_rsp_valid  out  1             response FIFO not empty
//  core_rsp_data   out  DATA_WIDTH    read data at FIFO head
//  core_rsp_tag    out  TAG_WIDTH     tag at FIFO head
//  core_rsp_ready  in   1             core accepts the response
//  mem_req_valid   out  1             to adapter; data/tag/addr/byteen/rw fields mirror the core_req_* fields
//  mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data, mem_req_tag   out   (widths as core_req_*)
//  mem_req_ready   in   1             from adapter
//  mem_rsp_valid   in   1             from adapter (AXI rvalid)
//  mem_rsp_data    in   DATA_WIDTH    read data
//  mem_rsp_tag     in   TAG_WIDTH     read tag (AXI rid)
//  mem_rsp_ready   out  1             constant 1'b1
//  perf_reads, perf_writes, perf_credit_stalls  out  32   present only with VX_MEM_PERF_EN
// BEHAVIOUR
//  Reset values
//   - Both FIFOs are empty, so core_req_ready=1, core_rsp_valid=0, mem_req_valid=0.
//   - credits=RSP_DEPTH; perf counters=0.
//  Request path
//   - Push on core_req_valid&&core_req_ready.
//   - FIFO is registered, no bypass: a request pushed in cycle N is first presented on mem_req_* in cycle N+1.
//   - mem_req_valid = !req_empty && (head.rw || credits!=0).
//   - Pop on mem_req_valid&&mem_req_ready.
//   - Push and pop in the same cycle while full is not allowed (ready is based on full only).
//   - Push and pop in the same cycle while not full: count unchanged.
//  Credits: counter width $clog2(RSP_DEPTH+1); it has no other state.
//   - Decrement by 1 on a read issue (mem_req fire && !rw).
//   - Increment by 1 on a response pop (core_rsp_valid&&core_rsp_ready).
//   - Both in the same cycle: unchanged.
//   - Never exceeds RSP_DEPTH; never goes below 0.
//   - credits==0 with a read at the head: the head stalls; writes are not reordered around it (in-order).
//  Response path
//   - Push on mem_rsp_valid. Credits guarantee space.
//   - Push while full is a RUNTIME_ASSERT error.
//   - Head is visible on core_rsp_* the cycle after the push; the data stays stable until popped.
//   - Response order = adapter return order; tags are passed through unchanged.
//  Writes consume no credit and produce no core response (the adapter sinks B).
//  Reset mid-operation drops all queued requests/responses and restores the credits.
//   - The adapter and AXI slave must be reset in the same cycle.
// CONFIGURATION
//  VX_MEM_PERF_EN defined
//   - Adds three 32-bit wrapping counters, cleared on reset.
//   - perf_reads: read issues. perf_writes: write issues.
//   - perf_credit_stalls: cycles with a read at the head && credits==0.
//  VX_MEM_PERF_EN undefined: the perf_* ports and counters do not exist; no other change.
// STRUCTURE
//  Package vx_mem_pkg
//   - mem_req_t struct {rw, byteen, addr, data, tag}
//   - mem_rsp_t struct {data, tag}
//   - localparam PERF_CNT_WIDTH=32
//  Sub-module vx_mem_fifo #(type T, DEPTH)
//   - Generic synchronous FIFO with full/empty; instantiated for the request and response paths.
//  Top level holds the credit counter, issue gating and perf counters.
// TESTING
//  1. Reset: core_req_ready=1, mem_req_valid=0, core_rsp_valid=0, credits=8.
//  2. Read addr 0x10 tag 0x5A, adapter ready
//     -> mem_req_valid one cycle later with addr 0x10.
//     -> Response data 0xABCD tag 0x5A -> core_rsp one cycle later; credits return to 8.
//  3. Credit exhaustion
//     - Stimulus: 9 reads, core_rsp_ready=0, responses returned.
//     - 8 reads issue; the 9th stalls (and perf_credit_stalls counts, with VX_MEM_PERF_EN).
//     - One core_rsp pop -> the 9th issues the next cycle.
//  4. Request backpressure
//     - Stimulus: mem_req_ready=0, 5 pushes.
//     - core_req_ready=0 after 4 pushes; order preserved on release.
//  5. Write then read with credits==0
//     - Write issues; the following read stalls; no core response for the write.
//     - perf_writes=1 with VX_MEM_PERF_EN.
//  6. Reset asserted with 3 requests and 2 responses queued
//     -> next cycle: empty FIFOs, credits=8, no spurious valids.

Source files
------------

// File: rtl/vx_mem_pkg.sv
// Shared types and constants for the Vortex memory credit buffer.
//   mem_req_t : one queued core request {rw, byteen, addr, data, tag}
//   mem_rsp_t : one queued read response {data, tag}
// The struct field widths come from the VX_* constants below.
// vx_mem_credit_buffer parameters must match these constants.
package vx_mem_pkg;

    localparam int VX_DATA_WIDTH   = 512;
    localparam int VX_ADDR_WIDTH   = 26;
    localparam int VX_TAG_WIDTH    = 8;
    localparam int VX_BYTEEN_WIDTH = VX_DATA_WIDTH / 8;
    localparam int PERF_CNT_WIDTH  = 32;

    typedef struct packed {
        logic                       rw;
        logic [VX_BYTEEN_WIDTH-1:0] byteen;
        logic [VX_ADDR_WIDTH-1:0]   addr;
        logic [VX_DATA_WIDTH-1:0]   data;
        logic [VX_TAG_WIDTH-1:0]    tag;
    } mem_req_t;

    typedef struct packed {
        logic [VX_DATA_WIDTH-1:0] data;
        logic [VX_TAG_WIDTH-1:0]  tag;
    } mem_rsp_t;

endpackage

// File: rtl/vx_mem_fifo.sv
// Generic synchronous FIFO with full/empty flags and a registered storage array.
// There is no bypass path: an entry pushed in cycle N appears on head in cycle N+1.
//   clk, reset  : clock, synchronous active-high reset (empties the FIFO)
//   push, data  : write request and payload (ignored while full)
//   pop         : read request (ignored while empty)
//   head        : oldest entry, valid while !empty
//   full, empty : occupancy flags
module vx_mem_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  T     data,
    input  logic pop,
    output T     head,
    output logic full,
    output logic empty
);

    localparam int PTR_W = $clog2(DEPTH);

    T               mem [DEPTH];
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage is not reset: only the slots between the pointers are ever observed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[PTR_W-1:0]] <= data;
        end
    end

    // Read/write pointers carry one extra wrap bit to tell full from empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + {{PTR_W{1'b0}}, 1'b1};
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + {{PTR_W{1'b0}}, 1'b1};
            end
        end
    end

    assign head  = mem[rd_ptr[PTR_W-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

endmodule

// File: rtl/vx_mem_credit_buffer.sv
// Request/response buffering stage in front of the Vortex-to-AXI adapter.
// Core requests are queued in order and issued to the adapter. Reads are
// limited by a credit counter equal to the response FIFO depth. Each in-flight
// read therefore has a reserved response slot, so mem_rsp_ready is tied high.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   core_req_*          core request (valid/ready handshake, ready = request FIFO not full)
//   core_rsp_*          core response (valid = response FIFO not empty)
//   mem_req_*           request to the adapter, fields taken from the request FIFO head
//   mem_rsp_*           read response from the adapter, always accepted
//   perf_*              issue/stall counters, present only when VX_MEM_PERF_EN is defined
// Optional feature macro: VX_MEM_PERF_EN
module vx_mem_credit_buffer
    import vx_mem_pkg::*;
#(
    parameter int DATA_WIDTH   = VX_DATA_WIDTH,
    parameter int ADDR_WIDTH   = VX_ADDR_WIDTH,
    parameter int TAG_WIDTH    = VX_TAG_WIDTH,
    parameter int REQ_DEPTH    = 4,
    parameter int RSP_DEPTH    = 8,
    parameter int BYTEEN_WIDTH = DATA_WIDTH / 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    core_req_valid,
    input  logic                    core_req_rw,
    input  logic [BYTEEN_WIDTH-1:0] core_req_byteen,
    input  logic [ADDR_WIDTH-1:0]   core_req_addr,
    input  logic [DATA_WIDTH-1:0]   core_req_data,
    input  logic [TAG_WIDTH-1:0]    core_req_tag,
    output logic                    core_req_ready,
    output logic                    core_rsp_valid,
    output logic [DATA_WIDTH-1:0]   core_rsp_data,
    output logic [TAG_WIDTH-1:0]    core_rsp_tag,
    input  logic                    core_rsp_ready,
    output logic                    mem_req_valid,
    output logic                    mem_req_rw,
    output logic [BYTEEN_WIDTH-1:0] mem_req_byteen,
    output logic [ADDR_WIDTH-1:0]   mem_req_addr,
    output logic [DATA_WIDTH-1:0]   mem_req_data,
    output logic [TAG_WIDTH-1:0]    mem_req_tag,
    input  logic                    mem_req_ready,
    input  logic                    mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_rsp_data,
    input  logic [TAG_WIDTH-1:0]    mem_rsp_tag,
    output logic                    mem_rsp_ready
`ifdef VX_MEM_PERF_EN
   ,output logic [PERF_CNT_WIDTH-1:0] perf_reads,
    output logic [PERF_CNT_WIDTH-1:0] perf_writes,
    output logic [PERF_CNT_WIDTH-1:0] perf_credit_stalls
`endif
);

    localparam int CREDIT_W = $clog2(RSP_DEPTH + 1);
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(RSP_DEPTH);
    localparam logic [CREDIT_W-1:0] CREDIT_ONE = CREDIT_W'(1);

    mem_req_t            req_in;
    mem_req_t            req_head;
    logic                req_full;
    logic                req_empty;
    mem_rsp_t            rsp_in;
    mem_rsp_t            rsp_head;
    logic                rsp_full;
    logic                rsp_empty;
    logic                rsp_push;
    logic [CREDIT_W-1:0] credits;
    logic                head_is_read;
    logic                mem_fire;
    logic                read_issue;
    logic                rsp_pop;

    assign req_in = '{rw: core_req_rw, byteen: core_req_byteen, addr: core_req_addr,
                      data: core_req_data, tag: core_req_tag};

    vx_mem_fifo #(.T(mem_req_t), .DEPTH(REQ_DEPTH)) req_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (core_req_valid && core_req_ready),
        .data  (req_in),
        .pop   (mem_fire),
        .head  (req_head),
        .full  (req_full),
        .empty (req_empty)
    );

    assign core_req_ready = !req_full;
    assign head_is_read   = !req_empty && !req_head.rw;

    // A read at the head with no credit blocks everything behind it, keeping issue in order.
    assign mem_req_valid  = !req_empty && (req_head.rw || (credits != '0));
    assign mem_req_rw     = req_head.rw;
    assign mem_req_byteen = req_head.byteen;
    assign mem_req_addr   = req_head.addr;
    assign mem_req_data   = req_head.data;
    assign mem_req_tag    = req_head.tag;
    assign mem_fire       = mem_req_valid && mem_req_ready;
    assign read_issue     = mem_fire && !req_head.rw;

    // Credits reserve a response slot per in-flight read, so a full response FIFO is never pushed.
    assign rsp_in        = '{data: mem_rsp_data, tag: mem_rsp_tag};
    assign rsp_push      = mem_rsp_valid && !rsp_full;
    assign mem_rsp_ready = 1'b1;

    vx_mem_fifo #(.T(mem_rsp_t), .DEPTH(RSP_DEPTH)) rsp_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rsp_push),
        .data  (rsp_in),
        .pop   (rsp_pop),
        .head  (rsp_head),
        .full  (rsp_full),
        .empty (rsp_empty)
    );

    assign core_rsp_valid = !rsp_empty;
    assign core_rsp_data  = rsp_head.data;
    assign core_rsp_tag   = rsp_head.tag;
    assign rsp_pop        = core_rsp_valid && core_rsp_ready;

    // Credit counter: taken on read issue, returned when the core pops a response.
    always_ff @(posedge clk) begin
        if (reset) begin
            credits <= CREDIT_MAX;
        end else begin
            case ({read_issue, rsp_pop})
                2'b10: begin
                    if (credits != '0) begin
                        credits <= credits - CREDIT_ONE;
                    end
                end
                2'b01: begin
                    if (credits != CREDIT_MAX) begin
                        credits <= credits + CREDIT_ONE;
                    end
                end
                default: credits <= credits;
            endcase
        end
    end

`ifdef VX_MEM_PERF_EN
    localparam logic [PERF_CNT_WIDTH-1:0] PERF_ONE = PERF_CNT_WIDTH'(1);

    // Wrapping performance counters for issued reads/writes and credit-starved cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_reads         <= '0;
            perf_writes        <= '0;
            perf_credit_stalls <= '0;
        end else begin
            if (read_issue) begin
                perf_reads <= perf_reads + PERF_ONE;
            end
            if (mem_fire && req_head.rw) begin
                perf_writes <= perf_writes + PERF_ONE;
            end
            if (head_is_read && (credits == '0)) begin
                perf_credit_stalls <= perf_credit_stalls + PERF_ONE;
            end
        end
    end
`else
    logic unused_head_is_read;
    assign unused_head_is_read = head_is_read;
`endif

endmodule

// File: tb/tb_vx_mem_credit_buffer.sv
// Self-checking bench for vx_mem_credit_buffer: directed scenarios plus a
// randomized run checked against a queue-based reference model.
module tb_vx_mem_credit_buffer;

    localparam int DW = 512;
    localparam int AW = 26;
    localparam int TW = 8;
    localparam int BW = DW / 8;
    localparam int REQ_DEPTH = 4;
    localparam int RSP_DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          core_req_valid, core_req_rw, core_req_ready;
    logic [BW-1:0] core_req_byteen;
    logic [AW-1:0] core_req_addr;
    logic [DW-1:0] core_req_data;
    logic [TW-1:0] core_req_tag;
    logic          core_rsp_valid, core_rsp_ready;
    logic [DW-1:0] core_rsp_data;
    logic [TW-1:0] core_rsp_tag;
    logic          mem_req_valid, mem_req_rw, mem_req_ready;
    logic [BW-1:0] mem_req_byteen;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_data;
    logic [TW-1:0] mem_req_tag;
    logic          mem_rsp_valid, mem_rsp_ready;
    logic [DW-1:0] mem_rsp_data;
    logic [TW-1:0] mem_rsp_tag;
`ifdef VX_MEM_PERF_EN
    logic [31:0]   perf_reads, perf_writes, perf_credit_stalls;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic          rw;
        logic [BW-1:0] be;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
    } req_s;

    typedef struct {
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
    } rsp_s;

    always #5 clk = ~clk;

    vx_mem_credit_buffer dut (
        .clk(clk), .reset(reset),
        .core_req_valid(core_req_valid), .core_req_rw(core_req_rw),
        .core_req_byteen(core_req_byteen), .core_req_addr(core_req_addr),
        .core_req_data(core_req_data), .core_req_tag(core_req_tag),
        .core_req_ready(core_req_ready),
        .core_rsp_valid(core_rsp_valid), .core_rsp_data(core_rsp_data),
        .core_rsp_tag(core_rsp_tag), .core_rsp_ready(core_rsp_ready),
        .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
        .mem_req_byteen(mem_req_byteen), .mem_req_addr(mem_req_addr),
        .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
        .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .mem_rsp_tag(mem_rsp_tag), .mem_rsp_ready(mem_rsp_ready)
`ifdef VX_MEM_PERF_EN
       ,.perf_reads(perf_reads), .perf_writes(perf_writes),
        .perf_credit_stalls(perf_credit_stalls)
`endif
    );

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    function automatic logic [DW-1:0] rsp_pattern(input logic [TW-1:0] t);
        return {16{24'hC0DE00, t}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        core_req_valid = 1'b0; core_req_rw = 1'b0; core_req_byteen = '0;
        core_req_addr = '0; core_req_data = '0; core_req_tag = '0;
        core_rsp_ready = 1'b0; mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_tag = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Push n reads and act as an in-order adapter returning each read one cycle after issue.
    task automatic run_reads(input int n, input int cycles, output int issued);
        logic [TW-1:0] pend[$];
        int pushed = 0;
        issued = 0;
        mem_req_ready = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            core_req_valid = (pushed < n);
            core_req_rw    = 1'b0;
            core_req_addr  = AW'(32'h100 + pushed);
            core_req_tag   = TW'(32'h20 + pushed);
            if (pend.size() > 0) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_tag   = pend[0];
                mem_rsp_data  = rsp_pattern(pend[0]);
            end else begin
                mem_rsp_valid = 1'b0;
            end
            #3;
            if (core_req_valid && core_req_ready) pushed++;
            if (mem_rsp_valid) void'(pend.pop_front());
            if (mem_req_valid && mem_req_ready) begin
                issued++;
                pend.push_back(mem_req_tag);
            end
            tick();
        end
        core_req_valid = 1'b0;
        mem_rsp_valid  = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        #3;
        checks++; if (core_req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %0b want 1", core_req_ready); end
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_req_valid: got %0b want 0", mem_req_valid); end
        checks++; if (core_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_core_rsp_valid: got %0b want 0", core_rsp_valid); end
        checks++; if (dut.credits !== 4'd8) begin errors++; $display("FAIL reset_credits: got %0d want 8", dut.credits); end
        checks++; if (mem_rsp_ready !== 1'b1) begin errors++; $display("FAIL reset_mem_rsp_ready: got %0b want 1", mem_rsp_ready); end
`ifdef VX_MEM_PERF_EN
        checks++; if ({perf_reads, perf_writes, perf_credit_stalls} !== 96'd0) begin errors++; $display("FAIL reset_perf: got %0d/%0d/%0d want 0/0/0", perf_reads, perf_writes, perf_credit_stalls); end
`endif
    endtask

    task automatic test_single_read();
        apply_reset();
        mem_req_ready = 1'b1;
        core_req_valid = 1'b1; core_req_rw = 1'b0; core_req_addr = 26'h10; core_req_tag = 8'h5A;
        #3;
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL read_no_bypass: got %0b want 0", mem_req_valid); end
        tick();
        core_req_valid = 1'b0;
        #3;
        checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL read_issue_valid: got %0b want 1", mem_req_valid); end
        checks++; if ({mem_req_rw, mem_req_addr, mem_req_tag} !== {1'b0, 26'h10, 8'h5A}) begin errors++; $display("FAIL read_issue_fields: got rw=%0b addr=%h tag=%h want 0/010/5a", mem_req_rw, mem_req_addr, mem_req_tag); end
        tick();
        #3;
        checks++; if (dut.credits !== 4'd7) begin errors++; $display("FAIL read_credit_taken: got %0d want 7", dut.credits); end
        mem_rsp_valid = 1'b1; mem_rsp_data = DW'(16'hABCD); mem_rsp_tag = 8'h5A;
        tick();
        mem_rsp_valid = 1'b0;
        #3;
        checks++; if (core_rsp_valid !== 1'b1) begin errors++; $display("FAIL read_rsp_valid: got %0b want 1", core_rsp_valid); end
        checks++; if (core_rsp_data !== DW'(16'hABCD) || core_rsp_tag !== 8'h5A) begin errors++; $display("FAIL read_rsp_fields: got data=%h tag=%h want abcd/5a", core_rsp_data[31:0], core_rsp_tag); end
        core_rsp_ready = 1'b1;
        tick();
        core_rsp_ready = 1'b0;
        #3;
        checks++; if (core_rsp_valid !== 1'b0) begin errors++; $display("FAIL read_rsp_popped: got %0b want 0", core_rsp_valid); end
        checks++; if (dut.credits !== 4'd8) begin errors++; $display("FAIL read_credit_back: got %0d want 8", dut.credits); end
    endtask

    task automatic test_credit_exhaust();
        int issued;
        apply_reset();
        run_reads(9, 20, issued);
        #3;
        checks++; if (issued != 8) begin errors++; $display("FAIL exhaust_issued: got %0d want 8", issued); end
        checks++; if (mem_req_valid !== 1'b0 || dut.credits !== 4'd0) begin errors++; $display("FAIL exhaust_stall: got valid=%0b credits=%0d want 0/0", mem_req_valid, dut.credits); end
        checks++; if (core_rsp_tag !== 8'h20 || core_rsp_data !== rsp_pattern(8'h20)) begin errors++; $display("FAIL exhaust_rsp_head: got tag=%h want 20", core_rsp_tag); end
`ifdef VX_MEM_PERF_EN
        begin
            logic [31:0] s0;
            s0 = perf_credit_stalls;
            tick(); tick(); tick();
            #3;
            checks++; if (perf_credit_stalls !== s0 + 32'd3) begin errors++; $display("FAIL exhaust_perf_stalls: got %0d want %0d", perf_credit_stalls, s0 + 32'd3); end
        end
`endif
        core_rsp_ready = 1'b1;
        tick();
        core_rsp_ready = 1'b0;
        #3;
        checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 26'h108 || mem_req_tag !== 8'h28) begin errors++; $display("FAIL exhaust_ninth_issue: got valid=%0b addr=%h tag=%h want 1/108/28", mem_req_valid, mem_req_addr, mem_req_tag); end
        tick();
        mem_rsp_valid = 1'b1; mem_rsp_tag = 8'h28; mem_rsp_data = rsp_pattern(8'h28);
        tick();
        mem_rsp_valid = 1'b0;
        core_rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #3;
            checks++; if (core_rsp_valid !== 1'b1 || core_rsp_tag !== TW'(8'h21 + i)) begin errors++; $display("FAIL exhaust_drain_order: got valid=%0b tag=%h want 1/%h", core_rsp_valid, core_rsp_tag, TW'(8'h21 + i)); end
            tick();
        end
        core_rsp_ready = 1'b0;
        #3;
        checks++; if (core_rsp_valid !== 1'b0 || dut.credits !== 4'd8) begin errors++; $display("FAIL exhaust_final: got valid=%0b credits=%0d want 0/8", core_rsp_valid, dut.credits); end
    endtask

    task automatic test_backpressure();
        int got = 0;
        logic fifth_in = 1'b0;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            core_req_valid = 1'b1; core_req_rw = 1'b1; core_req_byteen = '1;
            core_req_addr = AW'(32'h200 + i); core_req_tag = TW'(32'h40 + i); core_req_data = rand_data();
            #3;
            checks++; if (core_req_ready !== (i < 4)) begin errors++; $display("FAIL bp_ready_%0d: got %0b want %0b", i, core_req_ready, (i < 4)); end
            if (i < 4) tick();
        end
        mem_req_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #3;
            if (core_req_valid && core_req_ready) fifth_in = 1'b1;
            if (mem_req_valid && mem_req_ready) begin
                checks++; if (mem_req_addr !== AW'(32'h200 + got) || mem_req_rw !== 1'b1) begin errors++; $display("FAIL bp_order: got addr=%h rw=%0b want %h/1", mem_req_addr, mem_req_rw, AW'(32'h200 + got)); end
                got++;
            end
            tick();
            if (fifth_in) core_req_valid = 1'b0;
        end
        #3;
        checks++; if (got != 5) begin errors++; $display("FAIL bp_count: got %0d want 5", got); end
        checks++; if (core_rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_no_write_rsp: got %0b want 0", core_rsp_valid); end
    endtask

    task automatic test_write_no_credit();
        int issued;
        int pops = 0;
        int fires = 0;
        apply_reset();
        run_reads(8, 16, issued);
        core_req_valid = 1'b1; core_req_rw = 1'b1; core_req_addr = 26'h300; core_req_tag = 8'h60;
        tick();
        core_req_rw = 1'b0; core_req_addr = 26'h301; core_req_tag = 8'h61;
        #3;
        checks++; if (mem_req_valid !== 1'b1 || mem_req_rw !== 1'b1 || mem_req_addr !== 26'h300) begin errors++; $display("FAIL wr_issue: got valid=%0b rw=%0b addr=%h want 1/1/300", mem_req_valid, mem_req_rw, mem_req_addr); end
        tick();
        core_req_valid = 1'b0;
        tick(); tick(); tick();
        #3;
        checks++; if (mem_req_valid !== 1'b0 || dut.credits !== 4'd0) begin errors++; $display("FAIL wr_read_stall: got valid=%0b credits=%0d want 0/0", mem_req_valid, dut.credits); end
`ifdef VX_MEM_PERF_EN
        checks++; if (perf_writes !== 32'd1 || perf_reads !== 32'd8) begin errors++; $display("FAIL wr_perf: got writes=%0d reads=%0d want 1/8", perf_writes, perf_reads); end
`endif
        core_rsp_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #3;
            if (core_rsp_valid) pops++;
            if (mem_req_valid && mem_req_ready) begin
                fires++;
                checks++; if (mem_req_addr !== 26'h301 || mem_req_rw !== 1'b0) begin errors++; $display("FAIL wr_late_read: got addr=%h rw=%0b want 301/0", mem_req_addr, mem_req_rw); end
            end
            tick();
        end
        core_rsp_ready = 1'b0;
        #3;
        checks++; if (pops != 8 || fires != 1) begin errors++; $display("FAIL wr_counts: got pops=%0d fires=%0d want 8/1", pops, fires); end
        checks++; if (dut.credits !== 4'd7) begin errors++; $display("FAIL wr_credits: got %0d want 7", dut.credits); end
    endtask

    task automatic test_reset_midop();
        int issued;
        apply_reset();
        run_reads(2, 8, issued);
        mem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            core_req_valid = 1'b1; core_req_rw = (i == 1); core_req_addr = AW'(32'h400 + i); core_req_tag = TW'(i);
            tick();
        end
        core_req_valid = 1'b0;
        #3;
        checks++; if (mem_req_valid !== 1'b1 || core_rsp_valid !== 1'b1 || dut.credits !== 4'd6) begin errors++; $display("FAIL midop_setup: got mvalid=%0b rvalid=%0b credits=%0d want 1/1/6", mem_req_valid, core_rsp_valid, dut.credits); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #3;
        checks++; if (core_req_ready !== 1'b1 || mem_req_valid !== 1'b0 || core_rsp_valid !== 1'b0) begin errors++; $display("FAIL midop_flags: got ready=%0b mvalid=%0b rvalid=%0b want 1/0/0", core_req_ready, mem_req_valid, core_rsp_valid); end
        checks++; if (dut.credits !== 4'd8) begin errors++; $display("FAIL midop_credits: got %0d want 8", dut.credits); end
        mem_req_ready = 1'b1; core_rsp_ready = 1'b1;
        tick(); tick();
        #3;
        checks++; if (mem_req_valid !== 1'b0 || core_rsp_valid !== 1'b0) begin errors++; $display("FAIL midop_spurious: got mvalid=%0b rvalid=%0b want 0/0", mem_req_valid, core_rsp_valid); end
    endtask

    task automatic test_random();
        req_s          mq[$];
        rsp_s          rq[$];
        logic [TW-1:0] pend[$];
        req_s          nr;
        rsp_s          nrsp;
        int            outstanding = 0;
        int            exp_credits;
        logic          exp_ready, exp_mvalid, exp_rvalid;
        int            m_reads = 0, m_writes = 0, m_stalls = 0;
        apply_reset();
        for (int c = 0; c < 2000; c++) begin
            nr.rw   = ($urandom_range(0, 3) == 0);
            nr.be   = {$urandom(), $urandom()};
            nr.addr = AW'($urandom());
            nr.data = rand_data();
            nr.tag  = TW'($urandom());
            core_req_valid = ($urandom_range(0, 2) != 0);
            core_req_rw = nr.rw; core_req_byteen = nr.be; core_req_addr = nr.addr;
            core_req_data = nr.data; core_req_tag = nr.tag;
            mem_req_ready  = ($urandom_range(0, 3) != 0);
            core_rsp_ready = (c % 400 < 200) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 1) == 1);
            if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
                mem_rsp_valid = 1'b1; mem_rsp_tag = pend[0]; mem_rsp_data = rand_data();
            end else begin
                mem_rsp_valid = 1'b0;
            end
            #3;
            exp_credits = RSP_DEPTH - outstanding;
            exp_ready   = (mq.size() < REQ_DEPTH);
            exp_mvalid  = (mq.size() != 0) && (mq[0].rw || exp_credits != 0);
            exp_rvalid  = (rq.size() != 0);
            checks++; if ({core_req_ready, mem_req_valid, core_rsp_valid} !== {exp_ready, exp_mvalid, exp_rvalid}) begin errors++; $display("FAIL rnd_flags c=%0d: got ready/mvalid/rvalid=%0b%0b%0b want %0b%0b%0b", c, core_req_ready, mem_req_valid, core_rsp_valid, exp_ready, exp_mvalid, exp_rvalid); end
            checks++; if (dut.credits !== 4'(exp_credits)) begin errors++; $display("FAIL rnd_credits c=%0d: got %0d want %0d", c, dut.credits, exp_credits); end
            if (exp_mvalid) begin
                checks++; if (mem_req_rw !== mq[0].rw || mem_req_addr !== mq[0].addr || mem_req_tag !== mq[0].tag || mem_req_data !== mq[0].data || mem_req_byteen !== mq[0].be) begin errors++; $display("FAIL rnd_mem_req c=%0d: got addr=%h tag=%h want addr=%h tag=%h", c, mem_req_addr, mem_req_tag, mq[0].addr, mq[0].tag); end
            end
            if (exp_rvalid) begin
                checks++; if (core_rsp_tag !== rq[0].tag || core_rsp_data !== rq[0].data) begin errors++; $display("FAIL rnd_core_rsp c=%0d: got tag=%h want %h", c, core_rsp_tag, rq[0].tag); end
            end
            if (mq.size() != 0 && !mq[0].rw && exp_credits == 0) m_stalls++;
            if (core_req_valid && exp_ready) mq.push_back(nr);
            if (exp_mvalid && mem_req_ready) begin
                if (mq[0].rw) begin
                    m_writes++;
                end else begin
                    m_reads++;
                    outstanding++;
                    pend.push_back(mq[0].tag);
                end
                void'(mq.pop_front());
            end
            if (mem_rsp_valid) begin
                nrsp.data = mem_rsp_data;
                nrsp.tag  = mem_rsp_tag;
                rq.push_back(nrsp);
                void'(pend.pop_front());
            end
            if (exp_rvalid && core_rsp_ready) begin
                void'(rq.pop_front());
                outstanding--;
            end
            tick();
        end
        idle_inputs();
        #3;
`ifdef VX_MEM_PERF_EN
        checks++; if (perf_reads !== 32'(m_reads) || perf_writes !== 32'(m_writes) || perf_credit_stalls !== 32'(m_stalls)) begin errors++; $display("FAIL rnd_perf: got %0d/%0d/%0d want %0d/%0d/%0d", perf_reads, perf_writes, perf_credit_stalls, m_reads, m_writes, m_stalls); end
`endif
        checks++; if (m_reads == 0 || m_writes == 0 || m_stalls == 0) begin errors++; $display("FAIL rnd_coverage: reads=%0d writes=%0d stalls=%0d want all nonzero", m_reads, m_writes, m_stalls); end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_single_read();
        test_credit_exhaust();
        test_backpressure();
        test_write_no_credit();
        test_reset_midop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
